// File: rtl/cdb_rr_arbiter.sv
`timescale 1ns/1ps
// Common data bus arbiter: round-robin grant among the station groups, one-cycle
// registered broadcast, and saturating conflict/broadcast statistics.
module cdb_rr_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int LW   = 5,
   parameter int CW   = 16
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data_in,
   input  logic [LW*NREQ-1:0] label_in,
   output logic [NREQ-1:0]    ack,
   output logic               bc_en,
   output logic [LW-1:0]      bc_label,
   output logic [DW-1:0]      bc_data,
   output logic [CW-1:0]      conflict_cnt,
   output logic [CW-1:0]      bc_cnt
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] r_ptr;
   logic          r_bc_en;
   logic [LW-1:0] r_bc_label;
   logic [DW-1:0] r_bc_data;
   logic [CW-1:0] r_conflict_cnt;
   logic [CW-1:0] r_bc_cnt;

   logic          w_found;
   logic [PW-1:0] w_win;
   logic          w_multi;
   logic [LW-1:0] w_win_label;
   logic [DW-1:0] w_win_data;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
      return (int'(w) == NREQ - 1) ? '0 : w + PW'(1);
   endfunction

   // Search upward from the pointer with wrap; first set request wins.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && req[idx]) begin
            w_found = 1'b1;
            w_win   = PW'(idx);
         end
      end
   end

   always_comb begin
      ack = '0;
      if (w_found && !nRST) ack[w_win] = 1'b1;
   end

   // Non-zero after clearing the lowest set bit means two or more requesters.
   assign w_multi     = |(req & (req - NREQ'(1)));
   assign w_win_label = label_in[int'(w_win)*LW +: LW];
   assign w_win_data  = data_in[int'(w_win)*DW +: DW];

   always_ff @(posedge clk or posedge nRST) begin
      if (nRST) begin
         r_ptr          <= '0;
         r_bc_en        <= 1'b0;
         r_bc_label     <= '0;
         r_bc_data      <= '0;
         r_conflict_cnt <= '0;
         r_bc_cnt       <= '0;
      end else begin
         r_bc_en <= |req;
         if (w_found) begin
            r_ptr      <= next_ptr(w_win);
            r_bc_label <= w_win_label;
            r_bc_data  <= w_win_data;
         end
         if (|req)   r_bc_cnt       <= sat_inc(r_bc_cnt);
         if (w_multi) r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
   end

   assign bc_en        = r_bc_en;
   assign bc_label     = r_bc_label;
   assign bc_data      = r_bc_data;
   assign conflict_cnt = r_conflict_cnt;
   assign bc_cnt       = r_bc_cnt;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for cdb_rr_arbiter: grant expectations checked in the request
// cycle, bus expectations queued and popped one edge later.
module tb_cdb_rr_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int LW   = 5;
   localparam int CW   = 16;

   logic               clk = 1'b0;
   logic               nRST;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] data_in;
   logic [LW*NREQ-1:0] label_in;
   logic [NREQ-1:0]    ack;
   logic               bc_en;
   logic [LW-1:0]      bc_label;
   logic [DW-1:0]      bc_data;
   logic [CW-1:0]      conflict_cnt;
   logic [CW-1:0]      bc_cnt;

   cdb_rr_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW), .CW(CW)) dut (
      .clk(clk), .nRST(nRST), .req(req), .data_in(data_in), .label_in(label_in),
      .ack(ack), .bc_en(bc_en), .bc_label(bc_label), .bc_data(bc_data),
      .conflict_cnt(conflict_cnt), .bc_cnt(bc_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic [LW-1:0] label;
      logic [DW-1:0] data;
   } bus_t;

   bus_t          exp_q[$];
   logic [LW-1:0] lbl[NREQ];
   logic [DW-1:0] dat[NREQ];
   int            m_ptr;
   logic          m_en;
   logic [LW-1:0] m_label;
   logic [DW-1:0] m_data;
   logic [CW-1:0] m_conf;
   logic [CW-1:0] m_bc;
   logic [NREQ-1:0] obs_ack;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NREQ; i++) begin
         data_in[i*DW +: DW]  = dat[i];
         label_in[i*LW +: LW] = lbl[i];
      end
   endtask

   // Reference: one clock edge of the arbiter as described behaviourally.
   task automatic model_edge(input logic [NREQ-1:0] r, output logic [NREQ-1:0] a);
      int w;
      int idx;
      w = -1;
      a = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (w < 0 && r[idx]) w = idx;
      end
      if (w >= 0) begin
         a[w]    = 1'b1;
         m_ptr   = (w + 1) % NREQ;
         m_label = lbl[w];
         m_data  = dat[w];
      end
      m_en = |r;
      if (r != '0 && m_bc != '1) m_bc++;
      if ($countones(r) >= 2 && m_conf != '1) m_conf++;
   endtask

   task automatic step(input logic [NREQ-1:0] r);
      logic [NREQ-1:0] ea;
      bus_t e;
      req = r;
      apply_inputs();
      #1;
      obs_ack = ack;
      model_edge(r, ea);
      check_eq("ack", ack, ea);
      e.en    = m_en;
      e.label = m_label;
      e.data  = m_data;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = exp_q.pop_front();
         check_eq("bc_en", bc_en, e.en);
         check_eq("bc_label", bc_label, e.label);
         check_eq("bc_data", bc_data, e.data);
      end
      check_eq("conflict_cnt", conflict_cnt, m_conf);
      check_eq("bc_cnt", bc_cnt, m_bc);
      @(negedge clk);
   endtask

   // Asserts reset between clock edges, checks the immediate clear, releases on the next negedge.
   task automatic do_reset();
      nRST = 1'b1;
      req  = '1;
      apply_inputs();
      #1;
      check_eq("rst_ack", ack, 0);
      check_eq("rst_bc_en", bc_en, 0);
      check_eq("rst_bc_label", bc_label, 0);
      check_eq("rst_bc_data", bc_data, 0);
      check_eq("rst_conflict", conflict_cnt, 0);
      check_eq("rst_bc_cnt", bc_cnt, 0);
      m_ptr = 0; m_en = 1'b0; m_label = '0; m_data = '0; m_conf = '0; m_bc = '0;
      exp_q.delete();
      @(negedge clk);
      req  = '0;
      nRST = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] ea;
      logic [NREQ-1:0] rr_exp[4];
      logic [CW-1:0]   saved_bc;
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      for (int i = 0; i < NREQ; i++) begin
         lbl[i] = LW'(i + 1);
         dat[i] = 32'hA000_0000 + DW'(i);
      end

      // Single requester
      do_reset();
      lbl[2] = 5'd7;
      dat[2] = 32'h0000_1234;
      step(3'b100);
      check_eq("single_ack", obs_ack, 3'b100);
      check_eq("single_en", bc_en, 1);
      check_eq("single_label", bc_label, 7);
      check_eq("single_data", bc_data, 32'h1234);
      step(3'b000);
      check_eq("single_drop_en", bc_en, 0);

      // Round-robin fairness
      do_reset();
      lbl[0] = 5'd11; lbl[1] = 5'd12; lbl[2] = 5'd13;
      for (int i = 0; i < 4; i++) begin
         step(3'b111);
         check_eq($sformatf("rr_ack%0d", i), obs_ack, rr_exp[i]);
      end
      check_eq("rr_conflict", conflict_cnt, 4);
      check_eq("rr_bc_cnt", bc_cnt, 4);

      // Pointer wrap: grant Mul so the pointer sits at 2
      step(3'b010);
      check_eq("wrap_mul", obs_ack, 3'b010);
      step(3'b011);
      check_eq("wrap_ack0", obs_ack, 3'b001);
      step(3'b011);
      check_eq("wrap_ack1", obs_ack, 3'b010);

      // Idle hold
      lbl[0] = 5'd3;
      step(3'b001);
      saved_bc = bc_cnt;
      for (int i = 0; i < 3; i++) begin
         step(3'b000);
         check_eq("idle_en", bc_en, 0);
         check_eq("idle_label", bc_label, 3);
      end
      check_eq("idle_bc_cnt", bc_cnt, saved_bc);
      step(3'b111);
      check_eq("idle_ptr", obs_ack, 3'b010);

      // Saturation of the conflict and broadcast counters
      do_reset();
      req = 3'b011;
      apply_inputs();
      for (int i = 0; i < (1 << CW) + 5; i++) begin
         model_edge(3'b011, ea);
         @(negedge clk);
      end
      check_eq("sat_conflict", conflict_cnt, 16'hFFFF);
      check_eq("sat_bc_cnt", bc_cnt, 16'hFFFF);
      check_eq("sat_model_conf", conflict_cnt, m_conf);
      check_eq("sat_label", bc_label, m_label);
      step(3'b011);
      check_eq("sat_hold", conflict_cnt, 16'hFFFF);
      step(3'b000);

      // Asynchronous reset in the middle of a broadcast
      lbl[1] = 5'd9;
      dat[1] = 32'hBEEF_0001;
      step(3'b010);
      check_eq("pre_rst_en", bc_en, 1);
      check_eq("pre_rst_label", bc_label, 9);
      do_reset();
      step(3'b010);
      check_eq("post_rst_ack", obs_ack, 3'b010);
      check_eq("post_rst_label", bc_label, 9);
      check_eq("post_rst_bc_cnt", bc_cnt, 1);
      step(3'b111);
      check_eq("post_rst_ptr", obs_ack, 3'b100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
Round-robin arbiter and registered driver for the common data bus (CDB). It sits between the three reservation-station groups (Mem, Mul, Add) and every CDB consumer: the register file and all stations. Each cycle it grants one pending broadcast request and returns a same-cycle accept. On the next clock edge it registers the winner's label and data onto the bus. It keeps fairness state and conflict statistics so no station group can starve.

Parameters:
NREQ, 3, number of requesters; bit 0 = Mem, bit 1 = Mul, bit 2 = Add.
DW, 32, broadcast data width.
LW, 5, station label width.
CW, 16, width of the statistics counters.

Ports:
clk  in  1  system clock, rising edge.
nRST  in  1  asynchronous reset, active-high (asserted = 1).
req  in  NREQ  broadcast request, one bit per requester.
data_in  in  NREQ*DW  requester data; slice i = [i*DW +: DW].
label_in  in  LW*NREQ  requester label; slice i = [i*LW +: LW].
ack  out  NREQ  one-hot accept, combinational, same cycle as the request.
bc_en  out  1  registered CDB valid.
bc_label  out  LW  registered CDB label.
bc_data  out  DW  registered CDB data.
conflict_cnt  out  CW  cycles in which more than one req bit was set; saturating.
bc_cnt  out  CW  total broadcasts issued; saturating.

Behaviour:
- Reset (nRST=1, asynchronous):
  - bc_en=0, bc_label=0, bc_data=0.
  - conflict_cnt=0, bc_cnt=0.
  - Round-robin pointer ptr=0.
  - ack is combinational, so it is forced to 0 while nRST=1.
- Arbitration (combinational):
  - Search req starting at index ptr, upward with wrap modulo NREQ.
  - The first set bit wins; ack = one-hot of the winner.
  - req=0 gives ack=0.
  - ack is at most one-hot and never set for a requester whose req is 0.
- Pointer update, on a clock edge with any ack set: ptr <= (winner+1) mod NREQ. If ack=0, ptr holds.
- Bus register, on every clock edge:
  - bc_en <= |req.
  - When a winner exists: bc_label <= label_in[winner], bc_data <= data_in[winner].
  - When no winner exists: bc_label and bc_data hold their previous values, and consumers must qualify them with bc_en.
  - Latency: request cycle N gives bus valid in cycle N+1, exactly one cycle.
- Requester contract:
  - A requester holds req, label and data stable until it sees ack high at a clock edge.
  - After that edge it may drop req or present a new result in the next cycle.
  - A non-acked requester keeps req asserted; it is guaranteed an ack within NREQ cycles.
- Back-to-back: the same requester may be granted in consecutive cycles only if no other req bit is set.
- Statistics:
  - conflict_cnt increments on each edge where popcount(req) >= 2.
  - bc_cnt increments on each edge where req != 0.
  - Both saturate at all-ones and do not wrap.
- Reset mid-operation: asserting nRST during an active broadcast clears bc_en on the spot. The pending broadcast is lost; the upstream flush is responsible for recovery.
- The block has no internal FIFO, so there is no full or empty condition. Back-pressure is expressed only through a withheld ack.

Test Plan:
- Single requester: after reset, req=3'b100, label_in[14:10]=5'd7, data_in[95:64]=32'h0000_1234 for one cycle, then req=0. Required: ack=3'b100 in the same cycle; next cycle bc_en=1, bc_label=7, bc_data=32'h1234; the cycle after, bc_en=0.
- Round-robin fairness: after reset, req=3'b111 held 4 cycles, each requester keeping its label. Required: ack sequence 001, 010, 100, 001; bc_label follows one cycle later; conflict_cnt=4, bc_cnt=4.
- Pointer wrap: from ptr=2 (last grant was to Mul), req=3'b011. Required: ack=3'b001 then, with req held, ack=3'b010.
- Idle hold: grant label 5'd3, then req=0 for 3 cycles. Required: bc_en=0, bc_label stays 3, ptr unchanged, bc_cnt unchanged.
- Saturation: force 2^CW+5 conflicting cycles (req=3'b011). Required: conflict_cnt=16'hFFFF and no wrap to 0.
- Asynchronous reset mid-broadcast: assert nRST=1 between edges while bc_en=1. Required: bc_en, bc_label, bc_data, both counters and ack go to 0 immediately, without waiting for a clock edge. After release, the first req=3'b010 is granted starting from ptr=0.
